game_board_multi: RTL and testbench
===================================

GAME_BOARD_MULTI -- requirements
Module: game_board_multi

Interface
REQ-001 The block SHALL have parameter GRID, default 9, giving the board side length in cells (2..15).
REQ-002 The block SHALL have parameter SHIPS, default 4, giving the ship cells each player places (1..GRID*GRID).
REQ-003 The block SHALL have derived parameter CW = $clog2(GRID), giving the coordinate field width.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a new game.
REQ-007 The block SHALL have port act, input, 1 bit: one-cycle pulse meaning "place ship" or "fire" at pos, depending on state.
REQ-008 The block SHALL have port pos, input, 2*CW bits: action cell, {row,col}.
REQ-009 The block SHALL have ports rd_xy_host and rd_xy_guest, input, 2*CW bits each: display read addresses, {row,col}.
REQ-010 The block SHALL have ports code_host and code_guest, output, 2 bits each: registered cell codes at the read addresses.
REQ-011 The block SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-012 The block SHALL have port res_valid, output, 1 bit: one-cycle pulse marking a completed action.
REQ-013 The block SHALL have port res_code, output, 2 bits: 00 placed, 01 hit, 10 miss, 11 rejected; valid only with res_valid.
REQ-014 The block SHALL have port winner, output, 1 bit: 0 host, 1 guest; valid only in OVER.
REQ-015 The block SHALL have ports hits_host and hits_guest, output, $clog2(SHIPS+1) bits each: hits scored by each player.

Function
REQ-016 Cell codes SHALL be 00 empty, 01 ship, 10 hit ship, 11 miss, stored in two GRID x GRID arrays (host, guest).
REQ-017 FSM states SHALL be IDLE=0, PLACE_H=1, PLACE_G=2, TURN_H=3, TURN_G=4, OVER=5.
REQ-018 start in any state SHALL clear both boards, both counters, res_valid and winner, and enter PLACE_H on the next cycle; act in that same cycle SHALL be ignored.
REQ-019 In PLACE_H, an act on an in-range empty host cell SHALL write 01 there, increment the placement counter and produce res 00.
REQ-020 In PLACE_H, an act at an occupied cell, or with row or col >= GRID, SHALL leave the board unchanged and produce res 11.
REQ-021 When the host placement counter reaches SHIPS, the FSM SHALL clear the counter and go to PLACE_G; PLACE_G SHALL place on the guest board with the same rules, then go to TURN_H.
REQ-022 In TURN_H, act SHALL target the guest board: 01 becomes 10 with res 01 and hits_host+1; 00 becomes 11 with res 10.
REQ-023 In TURN_H, act on a cell already 10 or 11, or out of range, SHALL produce res 11, change nothing, and keep the turn.
REQ-024 A valid shot SHALL pass the turn: TURN_H goes to TURN_G, which symmetrically targets the host board and updates hits_guest.
REQ-025 A hit that brings a counter to SHIPS SHALL enter OVER instead of passing the turn, with winner set to the shooter.
REQ-026 act in IDLE or OVER SHALL be ignored, with no res_valid.
REQ-027 res_valid SHALL assert exactly one cycle after the act cycle, and never on two consecutive cycles without two consecutive acts.
REQ-028 code_host and code_guest SHALL have 1-cycle latency in every state.
REQ-029 code_host and code_guest SHALL read the pre-write value when the read and write addresses collide.
REQ-030 code_host and code_guest SHALL return 00 for out-of-range read addresses.

Reset
REQ-031 When rst_n is low, the block SHALL asynchronously force state to IDLE, both boards to 00, all counters to 0, and code_host, code_guest, res_valid, res_code and winner to 0.
REQ-032 Reset asserted mid-game SHALL discard all progress; after release the block SHALL remain in IDLE until start.

Verification
REQ-033 Scenario: rst_n low, then start and 4 host acts at (0,0),(0,1),(0,2),(0,3) -> each act gives res 00, the FSM reaches PLACE_G after the 4th act, and code_host at (0,2) is 01.
REQ-034 Scenario: in PLACE_H, act at (0,0) twice, then at (9,0) -> responses are 00, 11, 11, and the placement counter is 1.
REQ-035 Scenario: TURN_H fires at a guest ship, then at an empty guest cell -> res 01 with hits_host=1 and state TURN_G, then the guest turn proceeds; re-firing on the same cell gives res 11 and the state is unchanged.
REQ-036 Scenario: host sinks all 4 guest cells -> state OVER, winner=0, and a subsequent act produces no res_valid.
REQ-037 Scenario: rst_n pulsed low during TURN_G -> state IDLE, all codes 00, hits 0, and outputs change without waiting for a clk edge.
REQ-038 Scenario: with GRID=5, SHIPS=2, a full game is played -> CW=3, an act at row 5 is rejected, and the game ends after 2 hits.

Source files
------------

// File: rtl/game_board_multi.sv
// Two-player placement/firing game: host and guest boards, turn FSM, registered
// display read ports and a one-cycle result pulse per accepted action.
module game_board_multi #(
    parameter int GRID  = 9,
    parameter int SHIPS = 4,
    localparam int CW   = $clog2(GRID),
    localparam int HW   = $clog2(SHIPS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            act,
    input  logic [2*CW-1:0] pos,
    input  logic [2*CW-1:0] rd_xy_host,
    input  logic [2*CW-1:0] rd_xy_guest,
    output logic [1:0]      code_host,
    output logic [1:0]      code_guest,
    output logic [2:0]      state,
    output logic            res_valid,
    output logic [1:0]      res_code,
    output logic            winner,
    output logic [HW-1:0]   hits_host,
    output logic [HW-1:0]   hits_guest
);
    localparam int N  = GRID * GRID;
    localparam int AW = $clog2(N);
    localparam logic [CW:0]   GRID_L     = (CW + 1)'(GRID);
    localparam logic [HW-1:0] SHIPS_L    = HW'(SHIPS);
    localparam logic [HW-1:0] LAST_PLACE = HW'(SHIPS - 1);

    localparam logic [1:0] C_EMPTY = 2'b00, C_SHIP = 2'b01, C_HIT = 2'b10, C_MISS = 2'b11;
    localparam logic [1:0] RES_PLACED = 2'b00, RES_HIT = 2'b01, RES_MISS = 2'b10, RES_REJ = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLACE_H = 3'd1,
        PLACE_G = 3'd2,
        TURN_H  = 3'd3,
        TURN_G  = 3'd4,
        OVER    = 3'd5
    } state_e;

    function automatic logic in_range(input logic [2*CW-1:0] xy);
        return ({1'b0, xy[2*CW-1:CW]} < GRID_L) && ({1'b0, xy[CW-1:0]} < GRID_L);
    endfunction

    // Out-of-range addresses are clamped to cell 0 so array reads stay in bounds.
    function automatic logic [AW-1:0] cell_idx(input logic [2*CW-1:0] xy);
        return in_range(xy) ? AW'(int'(xy[2*CW-1:CW]) * GRID + int'(xy[CW-1:0])) : '0;
    endfunction

    state_e        state_q, state_d;
    logic [HW-1:0] place_q, place_d, hh_q, hh_d, hg_q, hg_d, cnt;
    logic          win_q, win_d, rv_q, rv_d;
    logic [1:0]    rc_q, rc_d;
    logic [1:0]    host_q  [N];
    logic [1:0]    guest_q [N];
    logic [1:0]    ch_q, cg_q, cell_h, cell_g, tgt, wdat;
    logic          we_h, we_g, clr, act_ok;
    logic [AW-1:0] act_idx;

    assign act_ok  = in_range(pos);
    assign act_idx = cell_idx(pos);
    assign cell_h  = host_q[act_idx];
    assign cell_g  = guest_q[act_idx];

    always_comb begin
        state_d = state_q;
        place_d = place_q;
        hh_d    = hh_q;
        hg_d    = hg_q;
        win_d   = win_q;
        rv_d    = 1'b0;
        rc_d    = rc_q;
        we_h    = 1'b0;
        we_g    = 1'b0;
        wdat    = C_EMPTY;
        clr     = 1'b0;
        tgt     = C_EMPTY;
        cnt     = '0;
        if (start) begin
            clr     = 1'b1;
            state_d = PLACE_H;
            place_d = '0;
            hh_d    = '0;
            hg_d    = '0;
            win_d   = 1'b0;
        end else if (act) begin
            case (state_q)
                PLACE_H, PLACE_G: begin
                    tgt  = (state_q == PLACE_H) ? cell_h : cell_g;
                    rv_d = 1'b1;
                    if (act_ok && tgt == C_EMPTY) begin
                        rc_d = RES_PLACED;
                        wdat = C_SHIP;
                        we_h = (state_q == PLACE_H);
                        we_g = (state_q == PLACE_G);
                        if (place_q == LAST_PLACE) begin
                            place_d = '0;
                            state_d = (state_q == PLACE_H) ? PLACE_G : TURN_H;
                        end else begin
                            place_d = place_q + HW'(1);
                        end
                    end else begin
                        rc_d = RES_REJ;
                    end
                end
                TURN_H, TURN_G: begin
                    // The shooter targets the opponent's board.
                    tgt  = (state_q == TURN_H) ? cell_g : cell_h;
                    rv_d = 1'b1;
                    if (!act_ok || tgt[1]) begin
                        rc_d = RES_REJ;
                    end else begin
                        wdat    = (tgt == C_SHIP) ? C_HIT : C_MISS;
                        we_g    = (state_q == TURN_H);
                        we_h    = (state_q == TURN_G);
                        state_d = (state_q == TURN_H) ? TURN_G : TURN_H;
                        if (tgt == C_SHIP) begin
                            rc_d = RES_HIT;
                            cnt  = ((state_q == TURN_H) ? hh_q : hg_q) + HW'(1);
                            if (state_q == TURN_H) hh_d = cnt;
                            else                   hg_d = cnt;
                            if (cnt == SHIPS_L) begin
                                state_d = OVER;
                                win_d   = (state_q == TURN_G);
                            end
                        end else begin
                            rc_d = RES_MISS;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            place_q <= '0;
            hh_q    <= '0;
            hg_q    <= '0;
            win_q   <= 1'b0;
            rv_q    <= 1'b0;
            rc_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            place_q <= place_d;
            hh_q    <= hh_d;
            hg_q    <= hg_d;
            win_q   <= win_d;
            rv_q    <= rv_d;
            rc_q    <= rc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                host_q[i]  <= C_EMPTY;
                guest_q[i] <= C_EMPTY;
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                host_q[i]  <= C_EMPTY;
                guest_q[i] <= C_EMPTY;
            end
        end else begin
            if (we_h) host_q[act_idx]  <= wdat;
            if (we_g) guest_q[act_idx] <= wdat;
        end
    end

    // Display reads sample the board before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= 2'b00;
            cg_q <= 2'b00;
        end else begin
            ch_q <= in_range(rd_xy_host)  ? host_q[cell_idx(rd_xy_host)]   : 2'b00;
            cg_q <= in_range(rd_xy_guest) ? guest_q[cell_idx(rd_xy_guest)] : 2'b00;
        end
    end

    assign state      = state_q;
    assign res_valid  = rv_q;
    assign res_code   = rc_q;
    assign winner     = win_q;
    assign hits_host  = hh_q;
    assign hits_guest = hg_q;
    assign code_host  = ch_q;
    assign code_guest = cg_q;
endmodule

// File: tb/tb_game_board_multi.sv
// Randomized + directed bench for game_board_multi against a cell-array game model,
// plus a directed full game on a GRID=5/SHIPS=2 instance.
module tb_game_board_multi;
    localparam int G = 9, S = 4;

    logic       clk, rst_n, start, act;
    logic [7:0] pos, rd_xy_host, rd_xy_guest;
    logic [1:0] code_host, code_guest, res_code;
    logic [2:0] state;
    logic       res_valid, winner;
    logic [2:0] hits_host, hits_guest;

    logic       s_start, s_act;
    logic [5:0] s_pos, s_rdh, s_rdg;
    logic [1:0] s_ch, s_cg, s_rc, s_hh, s_hg;
    logic [2:0] s_state;
    logic       s_rv, s_win;

    game_board_multi #(.GRID(G), .SHIPS(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .act(act), .pos(pos),
        .rd_xy_host(rd_xy_host), .rd_xy_guest(rd_xy_guest),
        .code_host(code_host), .code_guest(code_guest), .state(state),
        .res_valid(res_valid), .res_code(res_code), .winner(winner),
        .hits_host(hits_host), .hits_guest(hits_guest));

    game_board_multi #(.GRID(5), .SHIPS(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .act(s_act), .pos(s_pos),
        .rd_xy_host(s_rdh), .rd_xy_guest(s_rdg),
        .code_host(s_ch), .code_guest(s_cg), .state(s_state),
        .res_valid(s_rv), .res_code(s_rc), .winner(s_win),
        .hits_host(s_hh), .hits_guest(s_hg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0d exp %0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Game model: boards as 2-D cell arrays, state numbers as listed in the rules.
    int hb [G][G];
    int gb [G][G];
    int m_st, pc, hh, hg, win, exp_rc, exp_ch, exp_cg;
    bit exp_rv;

    function automatic int mget(input int side, input int r, input int c);
        return side ? gb[r][c] : hb[r][c];
    endfunction

    task automatic mput(input int side, input int r, input int c, input int v);
        if (side) gb[r][c] = v;
        else      hb[r][c] = v;
    endtask

    task automatic clear_boards();
        for (int r = 0; r < G; r++)
            for (int c = 0; c < G; c++) begin
                hb[r][c] = 0;
                gb[r][c] = 0;
            end
    endtask

    task automatic model_reset();
        clear_boards();
        m_st = 0; pc = 0; hh = 0; hg = 0; win = 0;
        exp_rv = 0; exp_rc = 0; exp_ch = 0; exp_cg = 0;
    endtask

    task automatic model_step(input bit st, input bit ac, input logic [7:0] p,
                              input logic [7:0] rh, input logic [7:0] rg);
        int r, c, side, v, hr, hc, gr, gc;
        bit ok;
        hr = int'(rh[7:4]); hc = int'(rh[3:0]);
        gr = int'(rg[7:4]); gc = int'(rg[3:0]);
        exp_ch = (hr < G && hc < G) ? hb[hr][hc] : 0;
        exp_cg = (gr < G && gc < G) ? gb[gr][gc] : 0;
        exp_rv = 0;
        if (st) begin
            clear_boards();
            m_st = 1; pc = 0; hh = 0; hg = 0; win = 0;
        end else if (ac && m_st >= 1 && m_st <= 4) begin
            exp_rv = 1;
            r = int'(p[7:4]); c = int'(p[3:0]);
            ok = (r < G) && (c < G);
            if (m_st <= 2) begin
                side = m_st - 1;
                if (ok && mget(side, r, c) == 0) begin
                    mput(side, r, c, 1);
                    exp_rc = 0;
                    pc++;
                    if (pc == S) begin pc = 0; m_st++; end
                end else exp_rc = 3;
            end else begin
                side = (m_st == 3) ? 1 : 0;
                if (!ok || mget(side, r, c) >= 2) exp_rc = 3;
                else if (mget(side, r, c) == 1) begin
                    mput(side, r, c, 2);
                    exp_rc = 1;
                    if (side == 1) begin hh++; v = hh; end
                    else           begin hg++; v = hg; end
                    if (v == S) begin win = (m_st == 4) ? 1 : 0; m_st = 5; end
                    else m_st = 7 - m_st;
                end else begin
                    mput(side, r, c, 3);
                    exp_rc = 2;
                    m_st = 7 - m_st;
                end
            end
        end
    endtask

    function automatic logic [7:0] xy(input int r, input int c);
        return {4'(r), 4'(c)};
    endfunction

    task automatic step(input bit st, input bit ac, input logic [7:0] p,
                        input logic [7:0] rh, input logic [7:0] rg);
        start = st; act = ac; pos = p; rd_xy_host = rh; rd_xy_guest = rg;
        model_step(st, ac, p, rh, rg);
        @(posedge clk); #1;
        chk("state", int'(state), m_st);
        chk("res_valid", int'(res_valid), int'(exp_rv));
        if (exp_rv) chk("res_code", int'(res_code), exp_rc);
        chk("hits_host", int'(hits_host), hh);
        chk("hits_guest", int'(hits_guest), hg);
        if (m_st == 5) chk("winner", int'(winner), win);
        chk("code_host", int'(code_host), exp_ch);
        chk("code_guest", int'(code_guest), exp_cg);
        start = 0; act = 0;
    endtask

    // Called 1 time unit after a rising edge; the checks land between edges.
    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_state", int'(state), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_code", int'(res_code), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_hits_host", int'(hits_host), 0);
        chk("rst_hits_guest", int'(hits_guest), 0);
        chk("rst_code_host", int'(code_host), 0);
        chk("rst_code_guest", int'(code_guest), 0);
        #1 rst_n = 1;
    endtask

    function automatic logic [5:0] xy5(input int r, input int c);
        return {3'(r), 3'(c)};
    endfunction

    task automatic act5(input logic [5:0] p, input int erc, input int est);
        s_act = 1; s_pos = p;
        @(posedge clk); #1;
        s_act = 0;
        chk("g5_res_valid", int'(s_rv), 1);
        chk("g5_res_code", int'(s_rc), erc);
        chk("g5_state", int'(s_state), est);
    endtask

    initial begin
        bit st, ac;
        start = 0; act = 0; pos = 0; rd_xy_host = 0; rd_xy_guest = 0;
        s_start = 0; s_act = 0; s_pos = 0; s_rdh = 0; s_rdg = 0;
        model_reset();
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("init_state", int'(state), 0);
        chk("init_res_valid", int'(res_valid), 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Placement with duplicate and out-of-range rejects, then a game up to TURN_G.
        step(0, 1, xy(1, 1), 0, 0);
        step(1, 1, xy(2, 2), 0, 0);
        step(0, 1, xy(0, 0), 0, 0);
        step(0, 1, xy(0, 0), 0, 0);
        step(0, 1, xy(9, 0), 0, 0);
        for (int c = 1; c < 4; c++) step(0, 1, xy(0, c), 0, 0);
        step(0, 0, 0, xy(0, 2), xy(0, 2));
        for (int c = 0; c < 4; c++) step(0, 1, xy(0, c), 0, 0);
        step(0, 1, xy(0, 0), 0, xy(0, 0));
        step(0, 1, xy(5, 5), 0, xy(0, 0));
        step(0, 1, xy(0, 0), xy(5, 5), 0);
        step(0, 1, xy(0, 1), 0, 0);
        step(0, 1, xy(5, 6), 0, 0);
        step(0, 1, xy(0, 2), 0, 0);
        do_reset();
        step(0, 1, xy(1, 1), xy(0, 0), xy(0, 0));
        step(0, 0, 0, xy(5, 5), xy(0, 1));

        // Full game: host sinks every guest ship, then acts in OVER are ignored.
        step(1, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) step(0, 1, xy(c, c), 0, 0);
        for (int c = 0; c < 4; c++) step(0, 1, xy(8, c), 0, 0);
        for (int c = 0; c < 4; c++) begin
            step(0, 1, xy(8, c), 0, xy(8, c));
            if (c < 3) step(0, 1, xy(4, c + 5), xy(c, c), 0);
        end
        step(0, 1, xy(4, 4), xy(4, 5), xy(8, 0));

        // Random play with occasional starts and asynchronous resets.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 699) == 0) do_reset();
            st = (m_st == 0 || m_st == 5) ? ($urandom_range(0, 4) == 0)
                                          : ($urandom_range(0, 199) == 0);
            ac = ($urandom_range(0, 9) < 7);
            step(st, ac, xy($urandom_range(0, 10), $urandom_range(0, 10)),
                 8'($urandom), 8'($urandom));
        end

        // Small-board game.
        s_start = 1;
        @(posedge clk); #1;
        s_start = 0;
        chk("g5_start_state", int'(s_state), 1);
        act5(xy5(0, 0), 0, 1);
        act5(xy5(5, 0), 3, 1);
        act5(xy5(0, 5), 3, 1);
        act5(xy5(1, 1), 0, 2);
        act5(xy5(2, 2), 0, 2);
        act5(xy5(3, 3), 0, 3);
        s_rdh = xy5(1, 1); s_rdg = xy5(2, 2);
        @(posedge clk); #1;
        chk("g5_code_host", int'(s_ch), 1);
        chk("g5_code_guest", int'(s_cg), 1);
        act5(xy5(2, 2), 1, 4);
        act5(xy5(4, 4), 2, 3);
        act5(xy5(3, 3), 1, 5);
        chk("g5_winner", int'(s_win), 0);
        chk("g5_hits_host", int'(s_hh), 2);
        chk("g5_hits_guest", int'(s_hg), 0);
        s_act = 1; s_pos = xy5(1, 1); s_rdh = xy5(6, 0); s_rdg = xy5(2, 2);
        @(posedge clk); #1;
        s_act = 0;
        @(posedge clk); #1;
        chk("g5_over_no_res", int'(s_rv), 0);
        chk("g5_over_state", int'(s_state), 5);
        chk("g5_oor_read", int'(s_ch), 0);
        chk("g5_hit_read", int'(s_cg), 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
